// File: rtl/seq_bcd2bin.sv
`default_nettype none
// ============================================================================
// Module   : seq_bcd2bin
// Brief    : Sequential packed-BCD to binary converter, one digit per cycle,
//            MSD first, with valid/ready handshakes on both sides.
//            Optional macro SEQ_BCD2BIN_EARLY_EXIT_EN: leave CALC on the
//            first digit above 9.
// Revision : 1.0  initial release
// ============================================================================
module seq_bcd2bin #(
  parameter int p_ndigits   = 2,
  parameter int p_out_nbits = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_val,
  output logic                     in_rdy,
  input  logic [4*p_ndigits-1:0]   in_,
  output logic                     out_val,
  input  logic                     out_rdy,
  output logic [p_out_nbits-1:0]   out,
  output logic                     out_err
);

  localparam int c_cnt_w = (p_ndigits > 1) ? $clog2(p_ndigits) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(p_ndigits - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [p_out_nbits-1:0]   acc_q, acc_d;
  logic [c_cnt_w-1:0]       cnt_q, cnt_d;
  logic                     err_q, err_d;
  logic [4*p_ndigits-1:0]   sr_q, sr_d;
  logic [3:0]               w_digit;
  logic                     w_digit_bad;

  // The unprocessed most significant digit always sits in the top nibble.
  assign w_digit     = sr_q[4*p_ndigits-1 -: 4];
  assign w_digit_bad = (w_digit > 4'd9);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    sr_d    = sr_q;
    case (state_q)
      IDLE: begin
        if (in_val) begin
          sr_d    = in_;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        // acc*10 as (acc<<3)+(acc<<1), truncated to the output width.
        acc_d = (acc_q << 3) + (acc_q << 1) + p_out_nbits'(w_digit);
        err_d = err_q | w_digit_bad;
        sr_d  = sr_q << 4;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == c_last) begin
          state_d = DONE;
        end
`ifdef SEQ_BCD2BIN_EARLY_EXIT_EN
        if (w_digit_bad) begin
          state_d = DONE;
        end
`else
`endif
      end
      DONE: begin
        if (out_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      sr_q    <= sr_d;
    end
  end

  always_comb begin
    in_rdy  = (state_q == IDLE);
    out_val = (state_q == DONE);
    out     = (out_val && !err_q) ? acc_q : '0;
    out_err = out_val & err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_bcd2bin.sv
`default_nettype none
// Testbench for seq_bcd2bin: a 2-digit and a 4-digit instance, random and
// directed conversions compared with a digit-arithmetic reference model.
module tb_seq_bcd2bin;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_val_a, in_rdy_a, out_val_a, out_rdy_a, out_err_a;
  logic [7:0]  in_a;
  logic [6:0]  out_a;
  logic        in_val_b, in_rdy_b, out_val_b, out_rdy_b, out_err_b;
  logic [15:0] in_b;
  logic [13:0] out_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_bcd2bin #(.p_ndigits(2), .p_out_nbits(7)) dut_a (
    .clk(clk), .reset(reset), .in_val(in_val_a), .in_rdy(in_rdy_a), .in_(in_a),
    .out_val(out_val_a), .out_rdy(out_rdy_a), .out(out_a), .out_err(out_err_a)
  );

  seq_bcd2bin #(.p_ndigits(4), .p_out_nbits(14)) dut_b (
    .clk(clk), .reset(reset), .in_val(in_val_b), .in_rdy(in_rdy_b), .in_(in_b),
    .out_val(out_val_b), .out_rdy(out_rdy_b), .out(out_b), .out_err(out_err_b)
  );

  // Reference: decimal value of the digits, zero on any digit above 9, and
  // the number of edges from accept to DONE.
  function automatic void ref_conv(input logic [31:0] v, input int nd,
                                   output int val, output bit err, output int lat);
    val = 0; err = 0; lat = nd;
    for (int i = nd - 1; i >= 0; i--) begin
      int d;
      d = int'((v >> (4 * i)) & 32'hF);
      if (d > 9 && !err) begin
        err = 1;
`ifdef SEQ_BCD2BIN_EARLY_EXIT_EN
        lat = nd - i;
`endif
      end
      val = val * 10 + d;
    end
    if (err) val = 0;
  endfunction

  function automatic bit get_rdy(input bit w);  return w ? in_rdy_b  : in_rdy_a;  endfunction
  function automatic bit get_val(input bit w);  return w ? out_val_b : out_val_a; endfunction
  function automatic bit get_err(input bit w);  return w ? out_err_b : out_err_a; endfunction
  function automatic int get_out(input bit w);  return w ? int'(out_b) : int'(out_a); endfunction

  task automatic set_in(input bit w, input logic [31:0] v, input logic vld);
    if (w) begin in_b = v[15:0]; in_val_b = vld; end
    else   begin in_a = v[7:0];  in_val_a = vld; end
  endtask

  task automatic set_ordy(input bit w, input logic r);
    if (w) out_rdy_b = r; else out_rdy_a = r;
  endtask

  // Drives one conversion and reports what was observed; callers check.
  task automatic convert(input bit w, input logic [31:0] v, input int hold,
                         output int lat, output int res, output bit err,
                         output bit busy_bad, output bit stable_bad,
                         output bit timeout, output bit rdy_after);
    lat = 0; res = -1; err = 0; busy_bad = 0; stable_bad = 0; timeout = 0; rdy_after = 0;
    @(negedge clk);
    set_ordy(w, 1'b0);
    set_in(w, v, 1'b1);
    for (int i = 0; i < 20 && !get_rdy(w); i++) @(negedge clk);
    if (!get_rdy(w)) begin timeout = 1; set_in(w, v, 1'b0); return; end
    @(posedge clk);
    @(negedge clk);
    set_in(w, $urandom, 1'b1);
    forever begin
      if (get_val(w)) break;
      if (get_rdy(w)) busy_bad = 1;
      if (lat > 40) begin timeout = 1; break; end
      @(posedge clk); lat++;
      @(negedge clk);
      set_in(w, $urandom, 1'b1);
    end
    if (timeout) begin set_in(w, v, 1'b0); return; end
    if (get_rdy(w)) busy_bad = 1;
    res = get_out(w);
    err = get_err(w);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      if (!get_val(w) || get_out(w) != res || get_err(w) != err || get_rdy(w))
        stable_bad = 1;
      set_in(w, $urandom, 1'b1);
    end
    set_in(w, v, 1'b0);
    set_ordy(w, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rdy_after = get_rdy(w) && !get_val(w) && get_out(w) == 0 && !get_err(w);
    set_ordy(w, 1'b0);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (in_rdy_a !== 1'b1 || out_val_a !== 1'b0 || out_a !== 7'd0 || out_err_a !== 1'b0
        || in_rdy_b !== 1'b1 || out_val_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b val=%b out=%0d err=%b rdy_b=%b val_b=%b, required 1 0 0 0 1 0",
               in_rdy_a, out_val_a, out_a, out_err_a, in_rdy_b, out_val_b);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One conversion plus every inline comparison for it.
  task automatic run_and_check(input string name, input bit w, input logic [31:0] v, input int hold);
    int lat, res, elat, eval;
    bit err, eerr, busy_bad, stable_bad, timeout, rdy_after;
    ref_conv(v, w ? 4 : 2, eval, eerr, elat);
    convert(w, v, hold, lat, res, err, busy_bad, stable_bad, timeout, rdy_after);
    checks++;
    if (timeout) begin
      errors++;
      $display("FAIL %s timeout: in=%h no handshake within bound", name, v);
      return;
    end
    checks++;
    if (res !== eval || err !== eerr) begin
      errors++;
      $display("FAIL %s value: in=%h out=%0d err=%b, required out=%0d err=%b", name, v, res, err, eval, eerr);
    end
    checks++;
    if (lat !== elat) begin
      errors++;
      $display("FAIL %s latency: in=%h got %0d edges, required %0d", name, v, lat, elat);
    end
    checks++;
    if (busy_bad) begin
      errors++;
      $display("FAIL %s in_rdy_busy: in=%h in_rdy was 1 during CALC/DONE, required 0", name, v);
    end
    checks++;
    if (stable_bad) begin
      errors++;
      $display("FAIL %s stall_stable: in=%h outputs changed while stalled, required stable", name, v);
    end
    checks++;
    if (!rdy_after) begin
      errors++;
      $display("FAIL %s back_to_idle: in=%h not idle (in_rdy=1, outputs 0) after handshake", name, v);
    end
  endtask

  task automatic test_basic();
    run_and_check("conv_42", 0, 32'h42, 0);
  endtask

  task automatic test_back_to_back();
    run_and_check("b2b_99", 0, 32'h99, 0);
    run_and_check("b2b_00", 0, 32'h00, 0);
  endtask

  task automatic test_bad_digit();
    run_and_check("bad_1A", 0, 32'h1A, 0);
    run_and_check("bad_A1", 0, 32'hA1, 0);
    run_and_check("bad_FF", 0, 32'hFF, 1);
  endtask

  task automatic test_backpressure();
    run_and_check("stall_57", 0, 32'h57, 3);
  endtask

  task automatic test_reset_mid_calc();
    bit saw_val;
    @(negedge clk);
    in_a = 8'h88; in_val_a = 1'b1; out_rdy_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_val_a = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (in_rdy_a !== 1'b1 || out_val_a !== 1'b0 || out_a !== 7'd0 || out_err_a !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async: rdy=%b val=%b out=%0d err=%b, required 1 0 0 0",
               in_rdy_a, out_val_a, out_a, out_err_a);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_rdy_a !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_release: in_rdy=%b, required 1", in_rdy_a);
    end
    saw_val = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_val_a) saw_val = 1;
    end
    checks++;
    if (saw_val) begin
      errors++;
      $display("FAIL mid_reset_no_result: out_val=1 seen, required 0");
    end
    out_rdy_a = 1'b0;
    run_and_check("after_reset_13", 0, 32'h13, 0);
  endtask

  task automatic test_wide();
    run_and_check("wide_9999", 1, 32'h9999, 0);
    run_and_check("wide_0100", 1, 32'h0100, 1);
    run_and_check("wide_0B00", 1, 32'h0B00, 0);
    for (int i = 0; i < 6; i++)
      run_and_check("wide_rand", 1, 32'($urandom_range(0, 16'hFFFF)), int'($urandom_range(0, 2)));
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++)
      run_and_check("rand", 0, 32'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
  endtask

  initial begin
    reset = 1'b1;
    in_a = '0; in_val_a = 1'b0; out_rdy_a = 1'b0;
    in_b = '0; in_val_b = 1'b0; out_rdy_b = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_bad_digit();
    test_backpressure();
    test_reset_mid_calc();
    test_wide();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
